vrf_write_arbiter: RTL and testbench

- Shares the single VRF write port among NUM_REQ write_vrf lane requesters, one per router lane (4 lanes).
- Selects one requester in round-robin order and captures that requester's address and data.
- Drives the VRF write port until the VRF accepts the write, then returns a one-cycle write_gnt to the winning requester.
- Sits between the per-lane write_vrf blocks and the VRF bank write interface.

---
 rtl/vrf_write_arbiter_if.sv | 57 +++++
 rtl/vrf_write_arbiter.sv | 142 ++++++++++++++
 tb/tb_vrf_write_arbiter.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vrf_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// vrf_write_arbiter_if
// Bundles the requester side (per-lane write requests, addresses, data and
// grant pulses) and the VRF bank write port of the VRF write arbiter.
//
// Signals:
//   write_req     per-lane write request, held high until granted
//   vrf_dst_addr  per-lane destination address, slice i belongs to lane i
//   data_recv     per-lane write data, slice i belongs to lane i
//   write_gnt     one-hot, one-cycle grant pulse back to the winning lane
//   vrf_wr_en     VRF write enable
//   vrf_wr_addr   VRF write address
//   vrf_wr_data   VRF write data
//   vrf_wr_ready  VRF accepts the write when sampled high with vrf_wr_en
//
// Modports:
//   master  the arbiter (drives the VRF write port and the grants)
//   slave   the environment (lanes plus VRF bank)
// ---------------------------------------------------------------------------
interface vrf_write_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 1024,
  parameter int ADDR_WIDTH = 10
);

  logic [NUM_REQ-1:0]            write_req;
  logic [NUM_REQ*ADDR_WIDTH-1:0] vrf_dst_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] data_recv;
  logic [NUM_REQ-1:0]            write_gnt;
  logic                          vrf_wr_en;
  logic [ADDR_WIDTH-1:0]         vrf_wr_addr;
  logic [DATA_WIDTH-1:0]         vrf_wr_data;
  logic                          vrf_wr_ready;

  modport master (
    input  write_req,
    input  vrf_dst_addr,
    input  data_recv,
    input  vrf_wr_ready,
    output write_gnt,
    output vrf_wr_en,
    output vrf_wr_addr,
    output vrf_wr_data
  );

  modport slave (
    output write_req,
    output vrf_dst_addr,
    output data_recv,
    output vrf_wr_ready,
    input  write_gnt,
    input  vrf_wr_en,
    input  vrf_wr_addr,
    input  vrf_wr_data
  );

endinterface

// File: rtl/vrf_write_arbiter.sv
// ---------------------------------------------------------------------------
// vrf_write_arbiter
// Shares the single VRF write port among NUM_REQ lane requesters. A winner is
// chosen round-robin in IDLE, its address and data are captured, the write is
// held on the VRF port until the bank accepts it, and a one-cycle grant pulse
// is returned to the winner. Every output comes straight from a flop.
//
// Ports:
//   clk       clock, rising edge
//   rst       asynchronous, active-high reset
//   bus       vrf_write_arbiter_if.master (requests, grants, VRF write port)
//   busy      high whenever the FSM is outside IDLE
//   wr_count  number of completed writes, wraps modulo 2^CNT_WIDTH
// ---------------------------------------------------------------------------
module vrf_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 1024,
  parameter int ADDR_WIDTH = 10,
  parameter int PTR_WIDTH  = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  vrf_write_arbiter_if.master  bus,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] wr_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    ACK   = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [PTR_WIDTH-1:0]   ptr_q, ptr_d;
  logic [PTR_WIDTH-1:0]   winner_q, winner_d;
  logic                   wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic [NUM_REQ-1:0]     gnt_q, gnt_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

  logic [PTR_WIDTH-1:0]   rr_pick;
  logic [PTR_WIDTH-1:0]   cand;
  logic                   rr_valid;

  // Round-robin search starting just after the last granted lane. The loop
  // runs from the farthest candidate to the nearest so that the nearest
  // requesting lane is the last assignment and therefore wins.
  always_comb begin
    rr_pick  = '0;
    rr_valid = 1'b0;
    cand     = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = PTR_WIDTH'((int'(ptr_q) + k) % NUM_REQ);
      if (bus.write_req[cand]) begin
        rr_pick  = cand;
        rr_valid = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    winner_d = winner_q;
    wr_en_d  = wr_en_q;
    addr_d   = addr_q;
    data_d   = data_q;
    gnt_d    = '0;
    cnt_d    = cnt_q;

    case (state_q)
      IDLE: begin
        wr_en_d = 1'b0;
        // Address and data are captured here, so later changes on the lane
        // inputs cannot disturb a write already in flight.
        if (rr_valid) begin
          winner_d = rr_pick;
          addr_d   = bus.vrf_dst_addr[int'(rr_pick)*ADDR_WIDTH +: ADDR_WIDTH];
          data_d   = bus.data_recv[int'(rr_pick)*DATA_WIDTH +: DATA_WIDTH];
          wr_en_d  = 1'b1;
          state_d  = WRITE;
        end
      end

      WRITE: begin
        // The write completes even if the winner dropped its request; the
        // grant is issued regardless so the lane sees its write finish.
        if (bus.vrf_wr_ready) begin
          wr_en_d         = 1'b0;
          gnt_d[winner_q] = 1'b1;
          ptr_d           = winner_q;
          cnt_d           = cnt_q + CNT_WIDTH'(1);
          state_d         = ACK;
        end
      end

      ACK: begin
        // The grant pulse ends here; the winner drops its request on this
        // same edge, so one IDLE cycle suffices to avoid a stale re-grant.
        state_d = IDLE;
      end

      default: begin
        wr_en_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= PTR_WIDTH'(NUM_REQ - 1);
      winner_q <= '0;
      wr_en_q  <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      gnt_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      winner_q <= winner_d;
      wr_en_q  <= wr_en_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      gnt_q    <= gnt_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.write_gnt   = gnt_q;
  assign bus.vrf_wr_en   = wr_en_q;
  assign bus.vrf_wr_addr = addr_q;
  assign bus.vrf_wr_data = data_q;
  assign busy            = (state_q != IDLE);
  assign wr_count        = cnt_q;

endmodule

// File: tb/tb_vrf_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vrf_write_arbiter
// Self-checking bench for vrf_write_arbiter. Each write is modelled as a
// transaction: the winner is chosen from the pending-request set by the
// round-robin rule, and the expected port activity for that transaction is
// laid out cycle by cycle from the planned number of ready stalls. The
// counter is elaborated 8 bits wide here so that wrap-around is reached in
// a few hundred writes.
// ---------------------------------------------------------------------------
module tb_vrf_write_arbiter;

  localparam int NUM_REQ      = 4;
  localparam int DATA_WIDTH   = 1024;
  localparam int ADDR_WIDTH   = 10;
  localparam int PTR_WIDTH    = 2;
  localparam int TB_CNT_WIDTH = 8;

  logic                    clk;
  logic                    rst;
  logic                    busy;
  logic [TB_CNT_WIDTH-1:0] wrCount;

  vrf_write_arbiter_if #(
    .NUM_REQ   (NUM_REQ),
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) bus ();

  vrf_write_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .PTR_WIDTH (PTR_WIDTH),
    .CNT_WIDTH (TB_CNT_WIDTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .busy    (busy),
    .wr_count(wrCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  int                    lastGrant;
  int                    expCount;
  logic [NUM_REQ-1:0]    reqVec;
  logic [ADDR_WIDTH-1:0] reqAddr [NUM_REQ];
  logic [DATA_WIDTH-1:0] reqData [NUM_REQ];

  int cmpCount;
  int errCount;

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    cmpCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t",
               tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus();
    bus.write_req = reqVec;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.vrf_dst_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = reqAddr[i];
      bus.data_recv[i*DATA_WIDTH +: DATA_WIDTH]    = reqData[i];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DATA_WIDTH-1:0] randData();
    logic [DATA_WIDTH-1:0] d;
    for (int w = 0; w < DATA_WIDTH/32; w++) d[w*32 +: 32] = $urandom;
    return d;
  endfunction

  // First pending lane after the last granted one, wrapping around.
  function automatic int pickWinner(input logic [NUM_REQ-1:0] v, input int last);
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx;
      idx = (last + k) % NUM_REQ;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [NUM_REQ-1:0] oneHot(input int idx);
    logic [NUM_REQ-1:0] m;
    m = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

  // New lane traffic that must not influence the write in flight.
  task automatic scramble(input int protect);
    for (int i = 0; i < NUM_REQ; i++) begin
      reqAddr[i] = ADDR_WIDTH'($urandom);
      reqData[i] = randData();
    end
    reqVec = reqVec | (NUM_REQ'($urandom) & ~oneHot(protect));
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_en"},   64'(bus.vrf_wr_en), 64'(0));
    checkOutput({tag, "_gnt"},  64'(bus.write_gnt), 64'(0));
    checkOutput({tag, "_busy"}, 64'(busy),          64'(0));
    checkOutput({tag, "_cnt"},  64'(wrCount),       64'(expCount));
  endtask

  task automatic doReset(input int cycles);
    rst = 1'b1;
    #1;
    checkOutput("rst_en",   64'(bus.vrf_wr_en), 64'(0));
    checkOutput("rst_gnt",  64'(bus.write_gnt), 64'(0));
    checkOutput("rst_busy", 64'(busy), 64'(0));
    checkOutput("rst_cnt",  64'(wrCount), 64'(0));
    checkOutput("rst_addr", 64'(bus.vrf_wr_addr), 64'(0));
    checkOutput("rst_data", 64'(bus.vrf_wr_data == '0), 64'(1));
    for (int c = 0; c < cycles; c++) begin
      tick();
      checkOutput("rst_hold_en",  64'(bus.vrf_wr_en), 64'(0));
      checkOutput("rst_hold_gnt", 64'(bus.write_gnt), 64'(0));
    end
    rst       = 1'b0;
    lastGrant = NUM_REQ - 1;
    expCount  = 0;
  endtask

  // One complete arbitration pass, starting with the DUT idle and at least
  // one request pending. stall = number of edges with vrf_wr_ready low.
  task automatic runPass(input int stall, input bit dropReq, input bit noise,
                         output int won);
    int                    win;
    logic [ADDR_WIDTH-1:0] eAddr;
    logic [DATA_WIDTH-1:0] eData;

    win = pickWinner(reqVec, lastGrant);
    won = win;
    if (win < 0) begin
      checkOutput("pass_no_request", 64'(reqVec), 64'(1));
      return;
    end
    eAddr = reqAddr[win];
    eData = reqData[win];

    bus.vrf_wr_ready = 1'($urandom_range(0, 1));
    applyStimulus();
    tick();
    checkOutput("wr_en_rise", 64'(bus.vrf_wr_en),   64'(1));
    checkOutput("wr_addr",    64'(bus.vrf_wr_addr), 64'(eAddr));
    checkOutput("wr_data",    64'(bus.vrf_wr_data == eData), 64'(1));
    checkOutput("wr_gnt_low", 64'(bus.write_gnt),   64'(0));
    checkOutput("wr_busy",    64'(busy),            64'(1));

    if (dropReq) reqVec[win] = 1'b0;
    for (int s = 0; s < stall; s++) begin
      bus.vrf_wr_ready = 1'b0;
      if (noise) scramble(win);
      applyStimulus();
      tick();
      checkOutput("stall_en",   64'(bus.vrf_wr_en),   64'(1));
      checkOutput("stall_addr", 64'(bus.vrf_wr_addr), 64'(eAddr));
      checkOutput("stall_data", 64'(bus.vrf_wr_data == eData), 64'(1));
      checkOutput("stall_gnt",  64'(bus.write_gnt),   64'(0));
      checkOutput("stall_cnt",  64'(wrCount),         64'(expCount));
    end

    bus.vrf_wr_ready = 1'b1;
    if (noise) scramble(win);
    applyStimulus();
    tick();
    lastGrant = win;
    expCount  = (expCount + 1) % (1 << TB_CNT_WIDTH);
    checkOutput("ack_gnt",  64'(bus.write_gnt), 64'(oneHot(win)));
    checkOutput("ack_en",   64'(bus.vrf_wr_en), 64'(0));
    checkOutput("ack_busy", 64'(busy),          64'(1));
    checkOutput("ack_cnt",  64'(wrCount),       64'(expCount));

    reqVec[win] = 1'b0;
    if (noise) scramble(win);
    bus.vrf_wr_ready = 1'($urandom_range(0, 1));
    applyStimulus();
    tick();
    checkIdle("post_ack");
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int won;
    int passes;
    cmpCount  = 0;
    errCount  = 0;
    rst       = 1'b0;
    reqVec    = '0;
    lastGrant = NUM_REQ - 1;
    expCount  = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      reqAddr[i] = '0;
      reqData[i] = '0;
    end
    bus.vrf_wr_ready = 1'b0;
    applyStimulus();
    #2;

    $display("[TB] reset then single request on lane 2");
    doReset(3);
    reqAddr[2] = 10'h155;
    reqData[2] = {(DATA_WIDTH/8){8'hA5}};
    reqVec     = 4'b0100;
    runPass(0, 1'b0, 1'b0, won);
    checkOutput("t1_winner", 64'(won), 64'(2));
    checkOutput("t1_count",  64'(wrCount), 64'(1));

    $display("[TB] round-robin with all lanes requesting");
    tick();
    doReset(1);
    for (int i = 0; i < NUM_REQ; i++) begin
      reqAddr[i] = ADDR_WIDTH'($urandom);
      reqData[i] = randData();
    end
    reqVec = 4'b1111;
    for (int i = 0; i < NUM_REQ; i++) begin
      runPass(0, 1'b0, 1'b0, won);
      checkOutput("t2_order", 64'(won), 64'(i));
    end

    $display("[TB] backpressure on lane 1");
    reqVec = 4'b0010;
    runPass(5, 1'b0, 1'b1, won);
    checkOutput("t3_winner", 64'(won), 64'(1));
    reqVec = '0;
    applyStimulus();

    $display("[TB] fairness after a grant to lane 3");
    reqVec = 4'b1000;
    runPass(0, 1'b0, 1'b0, won);
    reqVec = 4'b1001;
    runPass(0, 1'b0, 1'b0, won);
    checkOutput("t4_first",  64'(won), 64'(0));
    runPass(0, 1'b0, 1'b0, won);
    checkOutput("t4_second", 64'(won), 64'(3));

    $display("[TB] reset in the middle of a stalled write");
    reqVec = 4'b0010;
    bus.vrf_wr_ready = 1'b0;
    applyStimulus();
    tick();
    checkOutput("t5_en_before", 64'(bus.vrf_wr_en), 64'(1));
    tick();
    tick();
    doReset(1);
    reqVec = reqVec | 4'b0001;
    runPass(1, 1'b0, 1'b0, won);
    checkOutput("t5_after_rst", 64'(won), 64'(0));
    runPass(0, 1'b0, 1'b0, won);
    checkOutput("t5_next", 64'(won), 64'(1));

    $display("[TB] randomized traffic through counter wrap");
    passes = (1 << TB_CNT_WIDTH) + 40;
    for (int n = 0; n < passes; n++) begin
      if (reqVec == '0) begin
        int idle;
        idle = $urandom_range(0, 2);
        for (int c = 0; c < idle; c++) begin
          bus.vrf_wr_ready = 1'($urandom_range(0, 1));
          applyStimulus();
          tick();
          checkIdle("idle");
        end
        reqVec = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
        for (int i = 0; i < NUM_REQ; i++) begin
          reqAddr[i] = ADDR_WIDTH'($urandom);
          reqData[i] = randData();
        end
      end
      runPass($urandom_range(0, 3), ($urandom_range(0, 9) == 0),
              1'($urandom_range(0, 1)), won);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
    $finish;
  end

endmodule
